// File: rtl/cordic_iterative_hs.sv
// Iterative CORDIC engine with rotation/vectoring modes, valid/ready handshakes
// on both sides, internal headroom bits and saturated x/y outputs.
// One micro-rotation is performed per clock; z uses a binary angle where
// full scale (1.0) represents pi, so z wraps naturally modulo 2*pi.
module cordic_iterative_hs #(
    parameter int N_FRAC     = 7,
    parameter int ITERATIONS = 6,
    parameter int GUARD_BITS = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic signed [N_FRAC:0] x_i,
    input  logic signed [N_FRAC:0] y_i,
    input  logic signed [N_FRAC:0] z_i,
    input  logic                 mode_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    output logic signed [N_FRAC:0] x_o,
    output logic signed [N_FRAC:0] y_o,
    output logic signed [N_FRAC:0] z_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i
);

    localparam int W  = N_FRAC + 1;
    localparam int WI = W + GUARD_BITS;
    localparam int CW = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;

    localparam logic [CW-1:0] LAST_ITER = CW'(ITERATIONS - 1);

    // floor(atan(2^-i) / pi * 2^15); rescaled to the configured angle width.
    localparam int T16 [16] = '{8192, 4836, 2555, 1297, 651, 325, 162, 81,
                                40, 20, 10, 5, 2, 1, 0, 0};

    localparam logic signed [WI-1:0] SAT_MAX = WI'((1 << N_FRAC) - 1);
    localparam logic signed [WI-1:0] SAT_MIN = WI'(-(1 << N_FRAC));

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_OUTPUT = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         counter_q, counter_d;
    logic signed [WI-1:0]  x_q, x_d;
    logic signed [WI-1:0]  y_q, y_d;
    logic signed [W-1:0]   z_q, z_d;
    logic                  mode_q, mode_d;

    logic signed [WI-1:0]  x_shift, y_shift;
    logic signed [WI-1:0]  x_step, y_step;
    logic signed [W-1:0]   z_step;
    logic signed [W-1:0]   angle;
    logic [3:0]            angle_idx;
    logic                  d_pos;

    // Clamp an internal headroom value into the external Q0.N_FRAC range.
    function automatic logic signed [W-1:0] saturate(input logic signed [WI-1:0] v);
        if (v > SAT_MAX) begin
            return W'(SAT_MAX);
        end else if (v < SAT_MIN) begin
            return W'(SAT_MIN);
        end
        return W'(v);
    endfunction

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept in IDLE, iterate in CALC, hold in OUTPUT until taken.
    // NOTE: every combinational output is given a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (in_valid_i)              state_d = S_CALC;
            S_CALC:   if (counter_q == LAST_ITER)  state_d = S_OUTPUT;
            S_OUTPUT: if (out_ready_i)             state_d = S_IDLE;
            default:                               state_d = S_IDLE;
        endcase
    end

    // Output logic: handshake flags from state, results straight from registers.
    always_comb begin
        in_ready_o  = (state_q == S_IDLE);
        out_valid_o = (state_q == S_OUTPUT);
        x_o         = saturate(x_q);
        y_o         = saturate(y_q);
        z_o         = z_q;
    end

    // One micro-rotation: direction from z sign (rotation) or y sign (vectoring).
    always_comb begin
        x_shift   = x_q >>> counter_q;
        y_shift   = y_q >>> counter_q;
        angle_idx = 4'(counter_q);
        angle     = W'(T16[angle_idx] >>> (15 - N_FRAC));
        d_pos     = mode_q ? y_q[WI-1] : ~z_q[W-1];
        if (d_pos) begin
            x_step = x_q - y_shift;
            y_step = y_q + x_shift;
            z_step = z_q - angle;
        end else begin
            x_step = x_q + y_shift;
            y_step = y_q - x_shift;
            z_step = z_q + angle;
        end
    end

    // Datapath next values: capture operands in IDLE, step them in CALC, else hold.
    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        z_d       = z_q;
        mode_d    = mode_q;
        counter_d = counter_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    x_d       = WI'(x_i);
                    y_d       = WI'(y_i);
                    z_d       = z_i;
                    mode_d    = mode_i;
                    counter_d = '0;
                end
            end
            S_CALC: begin
                x_d = x_step;
                y_d = y_step;
                z_d = z_step;
                if (counter_q != LAST_ITER) begin
                    counter_d = counter_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset clears them so the outputs read zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x_q       <= '0;
            y_q       <= '0;
            z_q       <= '0;
            mode_q    <= 1'b0;
            counter_q <= '0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            z_q       <= z_d;
            mode_q    <= mode_d;
            counter_q <= counter_d;
        end
    end

endmodule

// File: tb/tb_cordic_iterative_hs.sv
// Scoreboard bench for cordic_iterative_hs: a default-parameter instance
// (N_FRAC=7, ITERATIONS=6) and a wide instance (N_FRAC=11, ITERATIONS=12).
// Expected results come from an integer CORDIC model whose angle table is
// derived from $atan; monitors pop and compare on each output handshake.
module tb_cordic_iterative_hs;

    localparam int GB   = 2;
    localparam int NF_A = 7;
    localparam int IT_A = 6;
    localparam int NF_B = 11;
    localparam int IT_B = 12;
    localparam real PI  = 3.14159265358979323846;

    typedef struct {
        int x;
        int y;
        int z;
    } res_t;

    logic clk;
    logic rst;

    logic signed [NF_A:0] x_a, y_a, z_a, xo_a, yo_a, zo_a;
    logic mode_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a;

    logic signed [NF_B:0] x_b, y_b, z_b, xo_b, yo_b, zo_b;
    logic mode_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b;

    res_t q_a[$];
    res_t q_b[$];
    res_t e_a, e_b;

    int  t16 [16];
    int  n_checks = 0;
    int  n_pass   = 0;
    bit  bp_random = 0;
    bit  bp_level  = 1;

    cordic_iterative_hs #(.N_FRAC(NF_A), .ITERATIONS(IT_A), .GUARD_BITS(GB)) dut_a (
        .clk_i(clk), .rst_i(rst),
        .x_i(x_a), .y_i(y_a), .z_i(z_a), .mode_i(mode_a),
        .in_valid_i(in_valid_a), .in_ready_o(in_ready_a),
        .x_o(xo_a), .y_o(yo_a), .z_o(zo_a),
        .out_valid_o(out_valid_a), .out_ready_i(out_ready_a)
    );

    cordic_iterative_hs #(.N_FRAC(NF_B), .ITERATIONS(IT_B), .GUARD_BITS(GB)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .x_i(x_b), .y_i(y_b), .z_i(z_b), .mode_i(mode_b),
        .in_valid_i(in_valid_b), .in_ready_o(in_ready_b),
        .x_o(xo_b), .y_o(yo_b), .z_o(zo_b),
        .out_valid_o(out_valid_b), .out_ready_i(out_ready_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reinterpret v as a two's complement number of the given width.
    function automatic int wrap(input int v, input int bits);
        int m = 1 << bits;
        int r = v & (m - 1);
        if (r >= (m >> 1)) r -= m;
        return r;
    endfunction

    function automatic int clamp(input int v, input int nf);
        int lim = 1 << nf;
        if (v > lim - 1) return lim - 1;
        if (v < -lim)    return -lim;
        return v;
    endfunction

    // Reference CORDIC: greedy micro-rotations on plain integers.
    function automatic res_t model(input int x0, input int y0, input int z0,
                                   input bit mode, input int nf, input int iters);
        res_t r;
        int x = x0, y = y0, z = z0;
        int wi = nf + 1 + GB;
        for (int i = 0; i < iters; i++) begin
            int d  = mode ? ((y < 0) ? 1 : -1) : ((z >= 0) ? 1 : -1);
            int xs = x >>> i;
            int ys = y >>> i;
            int a  = t16[i] >>> (15 - nf);
            x = wrap(x - d * ys, wi);
            y = wrap(y + d * xs, wi);
            z = wrap(z - d * a, nf + 1);
        end
        r.x = clamp(x, nf);
        r.y = clamp(y, nf);
        r.z = z;
        return r;
    endfunction

    // Back-pressure driver for instance A; changes land 2 time units after the edge.
    initial begin
        out_ready_a = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            out_ready_a = bp_random ? 1'($urandom_range(0, 1)) : bp_level;
        end
    end

    // Monitor A: compare against the scoreboard on every output handshake.
    always @(negedge clk) begin
        if (!rst && out_valid_a && out_ready_a) begin
            check("a_result_expected", int'(q_a.size() > 0), 1);
            if (q_a.size() > 0) begin
                e_a = q_a.pop_front();
                check("a_x_o", int'(xo_a), e_a.x);
                check("a_y_o", int'(yo_a), e_a.y);
                check("a_z_o", int'(zo_a), e_a.z);
            end
        end
    end

    // Monitor B.
    always @(negedge clk) begin
        if (!rst && out_valid_b && out_ready_b) begin
            check("b_result_expected", int'(q_b.size() > 0), 1);
            if (q_b.size() > 0) begin
                e_b = q_b.pop_front();
                check("b_x_o", int'(xo_b), e_b.x);
                check("b_y_o", int'(yo_b), e_b.y);
                check("b_z_o", int'(zo_b), e_b.z);
            end
        end
    end

    // Present one operand set to A; returns #1 after the accepting edge.
    task automatic send_a(input int x, input int y, input int z, input bit mode, input bit push);
        int budget = 0;
        while (!in_ready_a && budget < 200) begin
            @(posedge clk); #1;
            budget++;
        end
        check("a_in_ready_wait", int'(in_ready_a), 1);
        x_a = 8'(x); y_a = 8'(y); z_a = 8'(z); mode_a = mode;
        in_valid_a = 1'b1;
        if (push) q_a.push_back(model(x, y, z, mode, NF_A, IT_A));
        @(posedge clk); #1;
        in_valid_a = 1'b0;
    endtask

    task automatic send_b(input int x, input int y, input int z, input bit mode);
        int budget = 0;
        while (!in_ready_b && budget < 200) begin
            @(posedge clk); #1;
            budget++;
        end
        check("b_in_ready_wait", int'(in_ready_b), 1);
        x_b = 12'(x); y_b = 12'(y); z_b = 12'(z); mode_b = mode;
        in_valid_b = 1'b1;
        q_b.push_back(model(x, y, z, mode, NF_B, IT_B));
        @(posedge clk); #1;
        in_valid_b = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t ex;
        int   budget;
        bit   saw;

        for (int i = 0; i < 16; i++)
            t16[i] = int'($floor($atan(2.0 ** (-i)) / PI * 32768.0 + 1.0e-6));

        rst = 1'b1;
        x_a = '0; y_a = '0; z_a = '0; mode_a = 1'b0; in_valid_a = 1'b0;
        x_b = '0; y_b = '0; z_b = '0; mode_b = 1'b0; in_valid_b = 1'b0;
        out_ready_b = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state.
        check("rst_a_x_o", int'(xo_a), 0);
        check("rst_a_y_o", int'(yo_a), 0);
        check("rst_a_z_o", int'(zo_a), 0);
        check("rst_a_out_valid", int'(out_valid_a), 0);
        check("rst_a_in_ready", int'(in_ready_a), 1);
        check("rst_b_in_ready", int'(in_ready_b), 1);
        check("rst_b_out_valid", int'(out_valid_b), 0);

        // Rotation of (64,0) by 0 with latency and single-cycle valid.
        ex.x = 106; ex.y = -2; ex.z = -1;
        q_a.push_back(ex);
        send_a(64, 0, 0, 1'b0, 1'b0);
        for (int k = 1; k <= IT_A + 1; k++) begin
            @(posedge clk); #1;
            check($sformatf("latency_valid_e%0d", k), int'(out_valid_a), int'(k == IT_A));
        end

        // Vectoring of (64,0).
        ex.x = 106; ex.y = 2; ex.z = 1;
        q_a.push_back(ex);
        send_a(64, 0, 0, 1'b1, 1'b0);

        // Saturation: internal x grows beyond the output range.
        send_a(127, 127, 0, 1'b1, 1'b1);
        ex = model(127, 127, 0, 1'b1, NF_A, IT_A);
        check("sat_model_clamped_x", ex.x, 127);

        // Back-pressure with ignored operand pulses in CALC and OUTPUT.
        budget = 0;
        while (!in_ready_a && budget < 50) begin @(posedge clk); #1; budget++; end
        bp_level = 1'b0;
        @(posedge clk); #1;
        ex = model(-90, 45, 70, 1'b0, NF_A, IT_A);
        send_a(-90, 45, 70, 1'b0, 1'b1);
        x_a = 8'(33); y_a = 8'(-77); z_a = 8'(12); mode_a = 1'b1;
        in_valid_a = 1'b1;
        @(posedge clk); #1;
        in_valid_a = 1'b0;
        budget = 0;
        while (!out_valid_a && budget < 50) begin @(posedge clk); #1; budget++; end
        check("bp_valid_seen", int'(out_valid_a), 1);
        for (int h = 0; h < 5; h++) begin
            check("bp_hold_valid", int'(out_valid_a), 1);
            check("bp_hold_in_ready", int'(in_ready_a), 0);
            check("bp_hold_x_o", int'(xo_a), ex.x);
            check("bp_hold_y_o", int'(yo_a), ex.y);
            check("bp_hold_z_o", int'(zo_a), ex.z);
            in_valid_a = (h == 1);
            @(posedge clk); #1;
        end
        in_valid_a = 1'b0;
        bp_level = 1'b1;
        @(posedge clk); #1;
        check("bp_release_in_ready", int'(in_ready_a), 1);
        check("bp_release_out_valid", int'(out_valid_a), 0);

        // Reset during iteration 3 aborts the transaction.
        send_a(100, -20, 40, 1'b0, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_x_o", int'(xo_a), 0);
        check("abort_y_o", int'(yo_a), 0);
        check("abort_z_o", int'(zo_a), 0);
        check("abort_in_ready", int'(in_ready_a), 1);
        saw = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (out_valid_a) saw = 1'b1;
            @(posedge clk); #1;
        end
        check("abort_no_valid", int'(saw), 0);
        send_a(-50, 80, -100, 1'b1, 1'b1);

        // Randomised traffic on A with random back-pressure.
        bp_random = 1'b1;
        for (int n = 0; n < 40; n++) begin
            send_a(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                   int'($urandom_range(0, 255)) - 128, 1'($urandom_range(0, 1)), 1'b1);
        end
        bp_random = 1'b0;
        bp_level  = 1'b1;

        // Wide instance: rotation of (1024,0) over z spanning [-pi, pi).
        for (int k = 0; k < 16; k++)
            send_b(1024, 0, -2048 + k * 256 + int'($urandom_range(0, 255)), 1'b0);

        budget = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && budget < 2000) begin
            @(posedge clk); #1;
            budget++;
        end
        check("drain_a_queue", q_a.size(), 0);
        check("drain_b_queue", q_b.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
